// File: rtl/fabric_config_loader.sv
// Serial configuration loader: hunts a sync word, shifts in one full fabric image and commits it atomically.
// Optional CRC-8 check of the payload is enabled by defining CFG_CRC_EN.
module fabric_config_loader #(
  parameter int          N_LT      = 11,
  parameter int          LT_BITS   = 33,
  parameter int          N_SB      = 20,
  parameter int          SB_BITS   = 16,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic                                  in_bit,
  input  logic                                  cfg_abort,
  output logic [N_LT*LT_BITS+N_SB*SB_BITS-1:0]  cfg_bits,
  output logic                                  cfg_busy,
  output logic                                  cfg_done,
  output logic                                  cfg_loaded,
  output logic                                  cfg_err
);

  localparam int CFG_W = N_LT*LT_BITS + N_SB*SB_BITS;
  localparam int CNT_W = $clog2(CFG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W-1);

`ifdef CFG_CRC_EN
  typedef enum logic [1:0] {HUNT, LOAD, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {HUNT, LOAD, COMMIT} state_t;
`endif

  state_t             state, state_d;
  logic [15:0]        window;
  logic [CFG_W-1:0]   shadow;
  logic [CNT_W-1:0]   cnt;

  logic win_shift, win_clr, load_start, load_shift, commit, discard;

`ifdef CFG_CRC_EN
  logic [7:0] crc, crc_rx;
  logic [2:0] crc_cnt;
  logic       chk_shift, crc_bad;

  // MSB-first CRC-8, polynomial 0x07
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    win_shift  = 1'b0;
    win_clr    = 1'b0;
    load_start = 1'b0;
    load_shift = 1'b0;
    commit     = 1'b0;
    discard    = 1'b0;
`ifdef CFG_CRC_EN
    chk_shift  = 1'b0;
    crc_bad    = 1'b0;
`endif
    // Abort outranks everything, including a pending commit
    if (cfg_abort) begin
      state_d = HUNT;
      win_clr = 1'b1;
      discard = 1'b1;
    end else begin
      case (state)
        HUNT: begin
          if (in_valid) begin
            win_shift = 1'b1;
            if ({window[14:0], in_bit} == SYNC_WORD) begin
              state_d    = LOAD;
              load_start = 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            load_shift = 1'b1;
            if (cnt == LAST_BIT) begin
`ifdef CFG_CRC_EN
              state_d = CHECK;
`else
              state_d = COMMIT;
`endif
            end
          end
        end
`ifdef CFG_CRC_EN
        CHECK: begin
          if (in_valid) begin
            chk_shift = 1'b1;
            if (crc_cnt == 3'd7) begin
              if ({crc_rx[6:0], in_bit} == crc) begin
                state_d = COMMIT;
              end else begin
                state_d = HUNT;
                crc_bad = 1'b1;
                win_clr = 1'b1;
              end
            end
          end
        end
`endif
        COMMIT: begin
          commit  = 1'b1;
          state_d = HUNT;
          win_clr = 1'b1;
        end
        default: begin
          state_d = HUNT;
          win_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window     <= '0;
      shadow     <= '0;
      cnt        <= '0;
      cfg_bits   <= '0;
      cfg_done   <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_done <= commit;
      if (win_clr)        window <= '0;
      else if (win_shift) window <= {window[14:0], in_bit};
      // First payload bit ends at the top of the shadow, last bit at bit 0
      if (discard)         shadow <= '0;
      else if (load_shift) shadow <= {shadow[CFG_W-2:0], in_bit};
      if (load_start)      cnt <= '0;
      else if (load_shift) cnt <= cnt + 1'b1;
      if (commit) begin
        cfg_bits   <= shadow;
        cfg_loaded <= 1'b1;
      end
    end
  end

`ifdef CFG_CRC_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc     <= '0;
      crc_rx  <= '0;
      crc_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (load_start) begin
        crc     <= '0;
        crc_rx  <= '0;
        crc_cnt <= '0;
      end else begin
        if (load_shift) crc <= crc8_step(crc, in_bit);
        if (chk_shift) begin
          crc_rx  <= {crc_rx[6:0], in_bit};
          crc_cnt <= crc_cnt + 3'd1;
        end
      end
      if (crc_bad)     cfg_err <= 1'b1;
      else if (commit) cfg_err <= 1'b0;
    end
  end

  assign cfg_busy = (state == LOAD) || (state == CHECK);
`else
  assign cfg_err  = 1'b0;
  assign cfg_busy = (state == LOAD);
`endif

endmodule
